tl_ul_arb2: RTL and testbench
=============================

TL_UL_ARB2 -- requirements
Module: tl_ul_arb2

Interface
REQ-001 Parameter MAX_OUTSTANDING, default 4, SHALL set the maximum A requests in flight per upstream port (range 1..7).
REQ-002 clock  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in{0,1}_a_valid / in{0,1}_a_ready  input / output  1 each  upstream A handshake per port.
REQ-005 in{0,1}_a_opcode, _param, _size  input  3 each  upstream A fields.
REQ-006 in{0,1}_a_source  input  2  upstream A source ID.
REQ-007 in{0,1}_a_address, _data  input  32 each; in{0,1}_a_mask  input  4; in{0,1}_a_corrupt  input  1.
REQ-008 out_a_valid / out_a_ready  output / input  1 each  downstream A handshake.
REQ-009 out_a_opcode, _param, _size, _source  output  3 each; out_a_address, _data  output  32; out_a_mask  output  4; out_a_corrupt  output  1.
REQ-010 out_d_valid / out_d_ready  input / output  1 each; out_d_opcode, _size, _source  input  3; out_d_data  input  32; out_d_denied, _corrupt  input  1.
REQ-011 in{0,1}_d_valid / in{0,1}_d_ready  output / input  1 each; in{0,1}_d_opcode, _size  output  3; in{0,1}_d_source  output  2; in{0,1}_d_data  output  32; in{0,1}_d_denied, _corrupt  output  1.
REQ-012 d_unexpected  output  1  sticky flag: D response arrived for a port with no outstanding request.

Function
REQ-013 A path SHALL be one registered stage (holding register); an accepted upstream beat appears on out_a_* the next cycle.
REQ-014 Holding register SHALL load when empty or draining in the same cycle (out_a_valid && out_a_ready), giving full throughput of one beat per cycle.
REQ-015 out_a_source SHALL be {port index, in_a_source}; all other A fields SHALL pass unmodified.
REQ-016 Port i is eligible when in{i}_a_valid is high and outstanding count[i] < MAX_OUTSTANDING.
REQ-017 Arbitration SHALL be round-robin: single eligible port wins; if both are eligible, the port not equal to register last wins.
REQ-018 last SHALL update to the winning port index only on an accepted beat.
REQ-019 in{i}_a_ready SHALL be high only for the winning port while the holding register can load; the loser's ready SHALL be low.
REQ-020 in{i}_a_ready SHALL depend combinationally on in{i}_a_valid only through arbitration; no cycle may accept two beats.
REQ-021 count[i] (3 bits) SHALL increment on an A accept from port i, decrement on a D fire routed to port i, and hold when both occur in the same cycle.
REQ-022 D path SHALL be combinational: out_d_source[2] selects port; in{sel}_d_valid = out_d_valid; other port's d_valid = 0; out_d_ready = in{sel}_d_ready.
REQ-023 in{i}_d_source SHALL be out_d_source[1:0]; other D fields SHALL pass unmodified to both ports.
REQ-024 A D fire to port i with count[i] = 0 SHALL set d_unexpected; count[i] SHALL stay 0 (no underflow).
REQ-025 d_unexpected SHALL clear only on reset.
REQ-026 Holding register contents SHALL stay stable while out_a_valid && !out_a_ready.

Reset
REQ-027 On reset: out_a_valid = 0, count[0] = count[1] = 0, last = 1 (port 0 wins first tie), d_unexpected = 0.
REQ-028 During reset all in{i}_a_ready SHALL be 0; reset mid-transfer SHALL drop the held beat without emitting it.

Verification
REQ-029 Both ports valid continuously, out_a_ready = 1, D echoing each A after 2 cycles -> out_a_source[2] alternates 0,1,0,1 starting with 0; one beat per cycle.
REQ-030 Port 0 only, address 0x1000_0000, source 2, out_d_valid held 0 -> four beats accepted, fifth blocked (in0_a_ready = 0); port 1 still accepted.
REQ-031 out_a_ready = 0 for 5 cycles with a beat held -> out_a_* stable, both upstream readies 0 after first accept; release -> beat drains, next loads same cycle.
REQ-032 Accept on port 1 and D fire for port 1 (out_d_source = 3'b101) same cycle with count[1] = 2 -> count[1] stays 2; in1_d_source = 2'b01, in0_d_valid = 0.
REQ-033 out_d_valid with source 3'b000 while count[0] = 0 -> d_unexpected = 1 next cycle, stays 1 until reset; count[0] = 0.
REQ-034 Reset asserted while out_a_valid = 1 -> out_a_valid = 0 next cycle, counts 0, first tie after reset granted to port 0.

Source files
------------

// File: rtl/tl_ul_arb2.sv
// Two-port TileLink-UL arbiter. It has one registered A stage with round-robin grant and
// per-port outstanding limits. The D path is combinational and routed by source bit 2.
module tl_ul_arb2 #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        reset,
  // upstream port 0, A channel
  input  logic        in0_a_valid,
  output logic        in0_a_ready,
  input  logic [2:0]  in0_a_opcode,
  input  logic [2:0]  in0_a_param,
  input  logic [2:0]  in0_a_size,
  input  logic [1:0]  in0_a_source,
  input  logic [31:0] in0_a_address,
  input  logic [31:0] in0_a_data,
  input  logic [3:0]  in0_a_mask,
  input  logic        in0_a_corrupt,
  // upstream port 1, A channel
  input  logic        in1_a_valid,
  output logic        in1_a_ready,
  input  logic [2:0]  in1_a_opcode,
  input  logic [2:0]  in1_a_param,
  input  logic [2:0]  in1_a_size,
  input  logic [1:0]  in1_a_source,
  input  logic [31:0] in1_a_address,
  input  logic [31:0] in1_a_data,
  input  logic [3:0]  in1_a_mask,
  input  logic        in1_a_corrupt,
  // downstream A channel
  output logic        out_a_valid,
  input  logic        out_a_ready,
  output logic [2:0]  out_a_opcode,
  output logic [2:0]  out_a_param,
  output logic [2:0]  out_a_size,
  output logic [2:0]  out_a_source,
  output logic [31:0] out_a_address,
  output logic [31:0] out_a_data,
  output logic [3:0]  out_a_mask,
  output logic        out_a_corrupt,
  // downstream D channel
  input  logic        out_d_valid,
  output logic        out_d_ready,
  input  logic [2:0]  out_d_opcode,
  input  logic [2:0]  out_d_size,
  input  logic [2:0]  out_d_source,
  input  logic [31:0] out_d_data,
  input  logic        out_d_denied,
  input  logic        out_d_corrupt,
  // upstream D channels
  output logic        in0_d_valid,
  input  logic        in0_d_ready,
  output logic [2:0]  in0_d_opcode,
  output logic [2:0]  in0_d_size,
  output logic [1:0]  in0_d_source,
  output logic [31:0] in0_d_data,
  output logic        in0_d_denied,
  output logic        in0_d_corrupt,
  output logic        in1_d_valid,
  input  logic        in1_d_ready,
  output logic [2:0]  in1_d_opcode,
  output logic [2:0]  in1_d_size,
  output logic [1:0]  in1_d_source,
  output logic [31:0] in1_d_data,
  output logic        in1_d_denied,
  output logic        in1_d_corrupt,
  output logic        d_unexpected
);

  localparam logic [2:0] LP_MAX = 3'(MAX_OUTSTANDING);

  logic        r_aValid;
  logic [2:0]  r_aOpcode;
  logic [2:0]  r_aParam;
  logic [2:0]  r_aSize;
  logic [2:0]  r_aSource;
  logic [31:0] r_aAddress;
  logic [31:0] r_aData;
  logic [3:0]  r_aMask;
  logic        r_aCorrupt;
  logic [2:0]  r_count [2];
  logic        r_last;
  logic        r_dUnexpected;

  logic [1:0]  w_valid;
  logic [1:0]  w_elig;
  logic [1:0]  w_grant;
  logic [1:0]  w_acc;
  logic [1:0]  w_dFire;
  logic        w_canLoad;
  logic        w_dSel;

  assign w_valid   = {in1_a_valid, in0_a_valid};
  assign w_elig[0] = w_valid[0] && (r_count[0] < LP_MAX);
  assign w_elig[1] = w_valid[1] && (r_count[1] < LP_MAX);

  // On a tie the port that did not win last time is granted.
  assign w_grant[0] = w_elig[0] && (!w_elig[1] || r_last);
  assign w_grant[1] = w_elig[1] && (!w_elig[0] || !r_last);

  assign w_canLoad   = !r_aValid || out_a_ready;
  assign w_acc       = (w_canLoad && !reset) ? w_grant : 2'b00;
  assign in0_a_ready = w_acc[0];
  assign in1_a_ready = w_acc[1];

  // The payload fields load only on an accept, so a stalled beat never changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_aValid <= 1'b0;
    end else if (w_canLoad) begin
      r_aValid <= |w_acc;
      if (w_acc[1]) begin
        r_aOpcode  <= in1_a_opcode;
        r_aParam   <= in1_a_param;
        r_aSize    <= in1_a_size;
        r_aSource  <= {1'b1, in1_a_source};
        r_aAddress <= in1_a_address;
        r_aData    <= in1_a_data;
        r_aMask    <= in1_a_mask;
        r_aCorrupt <= in1_a_corrupt;
      end else if (w_acc[0]) begin
        r_aOpcode  <= in0_a_opcode;
        r_aParam   <= in0_a_param;
        r_aSize    <= in0_a_size;
        r_aSource  <= {1'b0, in0_a_source};
        r_aAddress <= in0_a_address;
        r_aData    <= in0_a_data;
        r_aMask    <= in0_a_mask;
        r_aCorrupt <= in0_a_corrupt;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (|w_acc) begin
      r_last <= w_acc[1];
    end
  end

  assign out_a_valid   = r_aValid;
  assign out_a_opcode  = r_aOpcode;
  assign out_a_param   = r_aParam;
  assign out_a_size    = r_aSize;
  assign out_a_source  = r_aSource;
  assign out_a_address = r_aAddress;
  assign out_a_data    = r_aData;
  assign out_a_mask    = r_aMask;
  assign out_a_corrupt = r_aCorrupt;

  assign w_dSel        = out_d_source[2];
  assign in0_d_valid   = out_d_valid && !w_dSel;
  assign in1_d_valid   = out_d_valid && w_dSel;
  assign out_d_ready   = w_dSel ? in1_d_ready : in0_d_ready;
  assign w_dFire[0]    = in0_d_valid && in0_d_ready;
  assign w_dFire[1]    = in1_d_valid && in1_d_ready;

  assign in0_d_opcode  = out_d_opcode;
  assign in0_d_size    = out_d_size;
  assign in0_d_source  = out_d_source[1:0];
  assign in0_d_data    = out_d_data;
  assign in0_d_denied  = out_d_denied;
  assign in0_d_corrupt = out_d_corrupt;
  assign in1_d_opcode  = out_d_opcode;
  assign in1_d_size    = out_d_size;
  assign in1_d_source  = out_d_source[1:0];
  assign in1_d_data    = out_d_data;
  assign in1_d_denied  = out_d_denied;
  assign in1_d_corrupt = out_d_corrupt;

  // A response with nothing outstanding flags an error and leaves the count at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count[0]    <= '0;
      r_count[1]    <= '0;
      r_dUnexpected <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_acc[i] && !w_dFire[i]) begin
          r_count[i] <= r_count[i] + 3'd1;
        end else if (w_dFire[i] && !w_acc[i] && (r_count[i] != 3'd0)) begin
          r_count[i] <= r_count[i] - 3'd1;
        end
        if (w_dFire[i] && (r_count[i] == 3'd0)) begin
          r_dUnexpected <= 1'b1;
        end
      end
    end
  end

  assign d_unexpected = r_dUnexpected;

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Randomised bench for tl_ul_arb2. A queue-based reference model predicts grants and beats,
// and a separate monitor pops the expected beats as they leave the A channel.
module tb_tl_ul_arb2;

  localparam int MAXO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in0_a_valid = 0, in1_a_valid = 0;
  logic        in0_a_ready, in1_a_ready;
  logic [2:0]  in0_a_opcode = 0, in0_a_param = 0, in0_a_size = 0;
  logic [2:0]  in1_a_opcode = 0, in1_a_param = 0, in1_a_size = 0;
  logic [1:0]  in0_a_source = 0, in1_a_source = 0;
  logic [31:0] in0_a_address = 0, in0_a_data = 0, in1_a_address = 0, in1_a_data = 0;
  logic [3:0]  in0_a_mask = 0, in1_a_mask = 0;
  logic        in0_a_corrupt = 0, in1_a_corrupt = 0;
  logic        out_a_valid;
  logic        out_a_ready = 0;
  logic [2:0]  out_a_opcode, out_a_param, out_a_size, out_a_source;
  logic [31:0] out_a_address, out_a_data;
  logic [3:0]  out_a_mask;
  logic        out_a_corrupt;
  logic        out_d_valid = 0;
  logic        out_d_ready;
  logic [2:0]  out_d_opcode = 0, out_d_size = 0, out_d_source = 0;
  logic [31:0] out_d_data = 0;
  logic        out_d_denied = 0, out_d_corrupt = 0;
  logic        in0_d_valid, in1_d_valid;
  logic        in0_d_ready = 0, in1_d_ready = 0;
  logic [2:0]  in0_d_opcode, in0_d_size, in1_d_opcode, in1_d_size;
  logic [1:0]  in0_d_source, in1_d_source;
  logic [31:0] in0_d_data, in1_d_data;
  logic        in0_d_denied, in0_d_corrupt, in1_d_denied, in1_d_corrupt;
  logic        d_unexpected;

  tl_ul_arb2 #(.MAX_OUTSTANDING(MAXO)) dut (
    .clock(clock), .reset(reset),
    .in0_a_valid(in0_a_valid), .in0_a_ready(in0_a_ready), .in0_a_opcode(in0_a_opcode),
    .in0_a_param(in0_a_param), .in0_a_size(in0_a_size), .in0_a_source(in0_a_source),
    .in0_a_address(in0_a_address), .in0_a_data(in0_a_data), .in0_a_mask(in0_a_mask),
    .in0_a_corrupt(in0_a_corrupt),
    .in1_a_valid(in1_a_valid), .in1_a_ready(in1_a_ready), .in1_a_opcode(in1_a_opcode),
    .in1_a_param(in1_a_param), .in1_a_size(in1_a_size), .in1_a_source(in1_a_source),
    .in1_a_address(in1_a_address), .in1_a_data(in1_a_data), .in1_a_mask(in1_a_mask),
    .in1_a_corrupt(in1_a_corrupt),
    .out_a_valid(out_a_valid), .out_a_ready(out_a_ready), .out_a_opcode(out_a_opcode),
    .out_a_param(out_a_param), .out_a_size(out_a_size), .out_a_source(out_a_source),
    .out_a_address(out_a_address), .out_a_data(out_a_data), .out_a_mask(out_a_mask),
    .out_a_corrupt(out_a_corrupt),
    .out_d_valid(out_d_valid), .out_d_ready(out_d_ready), .out_d_opcode(out_d_opcode),
    .out_d_size(out_d_size), .out_d_source(out_d_source), .out_d_data(out_d_data),
    .out_d_denied(out_d_denied), .out_d_corrupt(out_d_corrupt),
    .in0_d_valid(in0_d_valid), .in0_d_ready(in0_d_ready), .in0_d_opcode(in0_d_opcode),
    .in0_d_size(in0_d_size), .in0_d_source(in0_d_source), .in0_d_data(in0_d_data),
    .in0_d_denied(in0_d_denied), .in0_d_corrupt(in0_d_corrupt),
    .in1_d_valid(in1_d_valid), .in1_d_ready(in1_d_ready), .in1_d_opcode(in1_d_opcode),
    .in1_d_size(in1_d_size), .in1_d_source(in1_d_source), .in1_d_data(in1_d_data),
    .in1_d_denied(in1_d_denied), .in1_d_corrupt(in1_d_corrupt),
    .d_unexpected(d_unexpected)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0]  op, prm, sz, src;
    logic [31:0] addr, data;
    logic [3:0]  mask;
    logic        corrupt;
    int          cyc;
  } beat_t;

  int    vectors = 0;
  int    miscompares = 0;
  int    cycle = 0;
  int    mCnt [2];
  int    mLast = 1;
  bit    mUnexp = 0;
  beat_t sbQ [$];
  logic [3:0] acceptLog [int];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic randFields(input int p);
    if (p == 0) begin
      in0_a_opcode = 3'($urandom); in0_a_param = 3'($urandom); in0_a_size = 3'($urandom);
      in0_a_source = 2'($urandom); in0_a_address = $urandom; in0_a_data = $urandom;
      in0_a_mask = 4'($urandom); in0_a_corrupt = 1'($urandom);
    end else begin
      in1_a_opcode = 3'($urandom); in1_a_param = 3'($urandom); in1_a_size = 3'($urandom);
      in1_a_source = 2'($urandom); in1_a_address = $urandom; in1_a_data = $urandom;
      in1_a_mask = 4'($urandom); in1_a_corrupt = 1'($urandom);
    end
  endtask

  task automatic randDFields();
    out_d_opcode = 3'($urandom); out_d_size = 3'($urandom); out_d_data = $urandom;
    out_d_denied = 1'($urandom); out_d_corrupt = 1'($urandom);
  endtask

  // Reference model: spec-level grant rule, outstanding counts and the one-deep A queue.
  task automatic modelStep();
    bit    sel, canLoad;
    bit    elig [2];
    bit    acc [2];
    bit    dFire [2];
    int    win;
    beat_t b;
    sel = out_d_source[2];
    checkOutput("in0_d_valid", in0_d_valid, out_d_valid && !sel);
    checkOutput("in1_d_valid", in1_d_valid, out_d_valid && sel);
    checkOutput("out_d_ready", out_d_ready, sel ? in1_d_ready : in0_d_ready);
    checkOutput("in0_d_source", in0_d_source, out_d_source[1:0]);
    checkOutput("in1_d_source", in1_d_source, out_d_source[1:0]);
    checkOutput("in0_d_fields", {in0_d_opcode, in0_d_size, in0_d_denied, in0_d_corrupt},
                {out_d_opcode, out_d_size, out_d_denied, out_d_corrupt});
    checkOutput("in1_d_fields", {in1_d_opcode, in1_d_size, in1_d_denied, in1_d_corrupt},
                {out_d_opcode, out_d_size, out_d_denied, out_d_corrupt});
    checkOutput("in0_d_data", in0_d_data, out_d_data);
    checkOutput("in1_d_data", in1_d_data, out_d_data);
    checkOutput("d_unexpected", d_unexpected, mUnexp);
    if (reset) begin
      checkOutput("in0_a_ready_rst", in0_a_ready, 0);
      checkOutput("in1_a_ready_rst", in1_a_ready, 0);
      sbQ.delete();
      mCnt[0] = 0; mCnt[1] = 0; mLast = 1; mUnexp = 0;
      return;
    end
    elig[0] = in0_a_valid && (mCnt[0] < MAXO);
    elig[1] = in1_a_valid && (mCnt[1] < MAXO);
    if (elig[0] && elig[1]) win = (mLast == 0) ? 1 : 0;
    else if (elig[0])       win = 0;
    else if (elig[1])       win = 1;
    else                    win = -1;
    canLoad = (sbQ.size() == 0) || out_a_ready;
    acc[0] = canLoad && (win == 0);
    acc[1] = canLoad && (win == 1);
    checkOutput("in0_a_ready", in0_a_ready, acc[0]);
    checkOutput("in1_a_ready", in1_a_ready, acc[1]);
    if (acc[0]) begin
      b = '{op: in0_a_opcode, prm: in0_a_param, sz: in0_a_size, src: {1'b0, in0_a_source},
            addr: in0_a_address, data: in0_a_data, mask: in0_a_mask,
            corrupt: in0_a_corrupt, cyc: cycle};
    end else if (acc[1]) begin
      b = '{op: in1_a_opcode, prm: in1_a_param, sz: in1_a_size, src: {1'b1, in1_a_source},
            addr: in1_a_address, data: in1_a_data, mask: in1_a_mask,
            corrupt: in1_a_corrupt, cyc: cycle};
    end
    if (win >= 0 && canLoad) begin
      sbQ.push_back(b);
      acceptLog[cycle] = {1'b1, b.src};
      mLast = win;
    end
    dFire[0] = out_d_valid && !sel && in0_d_ready;
    dFire[1] = out_d_valid && sel && in1_d_ready;
    for (int p = 0; p < 2; p++) begin
      if (dFire[p] && mCnt[p] == 0) mUnexp = 1;
      if (acc[p] && !dFire[p]) mCnt[p]++;
      else if (dFire[p] && !acc[p] && mCnt[p] > 0) mCnt[p]--;
    end
  endtask

  // Modes: 0 reset, 1 random with legal D, 2 port0 saturate, 3 stall, 4 both+echo,
  // 5 unexpected D, 6 idle, 7 port1 behind saturated port0, 8 unconstrained random.
  task automatic applyStimulus(input int mode);
    int p;
    logic [3:0] e;
    @(negedge clock);
    cycle++;
    reset = (mode == 0);
    randFields(0);
    randFields(1);
    randDFields();
    out_d_source = 3'($urandom);
    out_d_valid = 0;
    in0_d_ready = 1'($urandom);
    in1_d_ready = 1'($urandom);
    case (mode)
      0: begin
        in0_a_valid = 1'($urandom); in1_a_valid = 1'($urandom); out_a_ready = 1'($urandom);
      end
      1, 8: begin
        in0_a_valid = ($urandom_range(0, 3) != 0);
        in1_a_valid = ($urandom_range(0, 3) != 0);
        out_a_ready = ($urandom_range(0, 3) != 0);
        in0_d_ready = ($urandom_range(0, 3) != 0);
        in1_d_ready = ($urandom_range(0, 3) != 0);
        if (mode == 8) begin
          out_d_valid = ($urandom_range(0, 2) == 0);
        end else if ($urandom_range(0, 1) == 1 && (mCnt[0] > 0 || mCnt[1] > 0)) begin
          p = (mCnt[0] == 0) ? 1 : (mCnt[1] == 0) ? 0 : int'($urandom_range(0, 1));
          out_d_valid = 1;
          out_d_source = {p[0], 2'($urandom)};
        end
      end
      2, 7: begin
        in0_a_valid = 1; in0_a_address = 32'h1000_0000; in0_a_source = 2'd2;
        in1_a_valid = (mode == 7); out_a_ready = 1;
      end
      3: begin
        in0_a_valid = 1; in1_a_valid = 1; out_a_ready = 0;
      end
      4: begin
        in0_a_valid = 1; in1_a_valid = 1; out_a_ready = 1;
        in0_d_ready = 1; in1_d_ready = 1;
        if (acceptLog.exists(cycle - 2)) begin
          e = acceptLog[cycle - 2];
          if (mCnt[e[2]] > 0) begin
            out_d_valid = 1;
            out_d_source = e[2:0];
          end
        end
      end
      5: begin
        in0_a_valid = 0; in1_a_valid = 0; out_a_ready = 1;
        out_d_valid = 1; out_d_source = 3'b000; in0_d_ready = 1;
      end
      default: begin
        in0_a_valid = 0; in1_a_valid = 0; out_a_ready = 1;
      end
    endcase
    #2;
    modelStep();
  endtask

  // Monitor: compares the held beat against the queue head and pops it on a downstream fire.
  initial begin
    forever begin
      @(negedge clock);
      #3;
      if (!reset) begin
        if (out_a_valid) begin
          if (sbQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL a_spurious: out_a_valid=1 with no expected beat (cycle %0d)", cycle);
          end else begin
            checkOutput("out_a_hdr",
                        {out_a_opcode, out_a_param, out_a_size, out_a_source, out_a_mask, out_a_corrupt},
                        {sbQ[0].op, sbQ[0].prm, sbQ[0].sz, sbQ[0].src, sbQ[0].mask, sbQ[0].corrupt});
            checkOutput("out_a_address", out_a_address, sbQ[0].addr);
            checkOutput("out_a_data", out_a_data, sbQ[0].data);
            if (out_a_ready) void'(sbQ.pop_front());
          end
        end else if (sbQ.size() > 0 && sbQ[0].cyc < cycle) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL a_missing: out_a_valid=0, expected beat src=%0d (cycle %0d)",
                   sbQ[0].src, cycle);
        end
      end
    end
  end

  initial begin
    mCnt[0] = 0;
    mCnt[1] = 0;
    repeat (2) applyStimulus(0);
    applyStimulus(6);
    applyStimulus(5);
    repeat (3) applyStimulus(6);
    repeat (6) applyStimulus(2);
    repeat (6) applyStimulus(7);
    repeat (2) applyStimulus(6);
    applyStimulus(0);
    applyStimulus(6);
    repeat (6) applyStimulus(3);
    repeat (20) applyStimulus(4);
    repeat (200) applyStimulus(1);
    repeat (2) applyStimulus(3);
    applyStimulus(0);
    repeat (8) applyStimulus(4);
    repeat (300) applyStimulus(8);
    repeat (4) applyStimulus(6);
    checkOutput("queue_drained", sbQ.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
